// File: rtl/gate_tt_pkg.sv
// -----------------------------------------------------------------------------
// gate_tt_pkg
// Shared types and constants for the 2-input gate truth-table sequencer.
//   state_e  : sequencer states (IDLE / RUN / DONE)
//   PATTERN  : Gray-ordered {A,B} stimulus, element 0 applied first
//   TT_*     : expected truth tables, bit index {A,B}
// -----------------------------------------------------------------------------
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Packed so element [0] is the rightmost entry: 00, 10, 11, 01.
  // Only one input toggles between neighbouring steps.
  localparam logic [3:0][1:0] PATTERN = {2'b01, 2'b11, 2'b10, 2'b00};

  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_XOR = 4'b0110;

endpackage : gate_tt_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter with synchronous clear that sticks at all-ones.
//   clk    : clock
//   rst    : asynchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : count up by one unless already saturated
//   cnt_o  : registered count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/gate_tt_sequencer.sv
// -----------------------------------------------------------------------------
// gate_tt_sequencer
// Exerciser for a combinational 2-input gate. Drives {A,B} through the Gray
// sequence 00,10,11,01 (HOLD_CYCLES cycles each, LOOPS passes), samples the
// gate output on the last edge of each pattern window and compares it with
// EXP_TT[{A,B}].
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : run request, only honoured in IDLE
//   dut_o    : output of the gate under test
//   drv_a    : gate input A (registered)
//   drv_b    : gate input B (registered)
//   busy     : patterns being applied
//   done     : one-cycle pulse at run end
//   pass     : no mismatches in the last run; held until next accepted start
//   err_cnt  : saturating mismatch count
//   fail_vec : sticky per-pattern failure flags, bit index {A,B}
// -----------------------------------------------------------------------------
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned LOOPS       = 1,
  parameter logic [3:0]  EXP_TT      = TT_OR,
  parameter int          ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_o,
  output logic             drv_a,
  output logic             drv_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec
);

  // Counter widths kept at least one bit so HOLD_CYCLES/LOOPS of 1 still work.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [LOOP_W-1:0]  loop_q, loop_d;
  logic [1:0]         drv_q, drv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [3:0]         fail_q, fail_d;
  logic               err_clr;
  logic               err_inc;
  logic [1:0]         idx_nxt;

  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    loop_d  = loop_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_clr = 1'b0;
    err_inc = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 2'd0;
          hold_d  = '0;
          loop_d  = '0;
          drv_d   = PATTERN[0];
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 4'b0000;
          err_clr = 1'b1;
        end
      end

      RUN: begin
        if (hold_q == HOLD_LAST) begin
          // Sample edge: drv_q is the pattern the gate has seen all window.
          if (dut_o != EXP_TT[drv_q]) begin
            err_inc        = 1'b1;
            fail_d[drv_q]  = 1'b1;
          end
          hold_d = '0;
          idx_d  = idx_nxt;
          drv_d  = PATTERN[idx_nxt];
          if (idx_q == 2'd3) begin
            if (loop_q == LOOP_LAST) begin
              state_d = DONE;
              drv_d   = 2'b00;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              // err_cnt is still updating on this edge; any mismatch in the
              // run also leaves a fail_vec bit, so fail_d == 0 is the same
              // condition as a final count of zero.
              pass_d  = (fail_d == 4'b0000);
            end else begin
              loop_d = loop_q + LOOP_W'(1);
            end
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        drv_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      loop_q  <= '0;
      drv_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      loop_q  <= loop_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (err_clr),
    .inc_i (err_inc),
    .cnt_o (err_cnt)
  );

  assign drv_a    = drv_q[1];
  assign drv_b    = drv_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_q;

endmodule : gate_tt_sequencer

// File: tb/tb_gate_tt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_tt_sequencer
// Three sequencer instances with different parameters, each driving a
// modelled gate whose truth table the bench chooses per run. Expected
// results come from a simple model: the drive at cycle k of a run is
// PAT[(k / HOLD) % 4], and the final flags follow from the mismatch mask
// (gate table XOR expected table).
// -----------------------------------------------------------------------------
module tb_gate_tt_sequencer;
  import gate_tt_pkg::*;

  localparam int H0 = 4, L0 = 1;
  localparam int H1 = 4, L1 = 100;
  localparam int H2 = 1, L2 = 2;
  localparam logic [3:0] E0 = TT_OR;
  localparam logic [3:0] E1 = TT_OR;
  localparam logic [3:0] E2 = TT_XOR;

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] dut_o_v;
  logic [2:0] drv_a_v, drv_b_v, busy_v, done_v, pass_v;
  logic [7:0] err_v  [3];
  logic [3:0] fail_v [3];
  logic [3:0] gate_v [3];

  int total = 0;
  int bad   = 0;
  int pat [4] = '{0, 2, 3, 1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Modelled gates: purely combinational from the drive signals.
  assign dut_o_v[0] = gate_v[0][{drv_a_v[0], drv_b_v[0]}];
  assign dut_o_v[1] = gate_v[1][{drv_a_v[1], drv_b_v[1]}];
  assign dut_o_v[2] = gate_v[2][{drv_a_v[2], drv_b_v[2]}];

  gate_tt_sequencer #(.HOLD_CYCLES(H0), .LOOPS(L0), .EXP_TT(E0), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .dut_o(dut_o_v[0]),
    .drv_a(drv_a_v[0]), .drv_b(drv_b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_cnt(err_v[0]), .fail_vec(fail_v[0]));

  gate_tt_sequencer #(.HOLD_CYCLES(H1), .LOOPS(L1), .EXP_TT(E1), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .dut_o(dut_o_v[1]),
    .drv_a(drv_a_v[1]), .drv_b(drv_b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_cnt(err_v[1]), .fail_vec(fail_v[1]));

  gate_tt_sequencer #(.HOLD_CYCLES(H2), .LOOPS(L2), .EXP_TT(E2), .ERR_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .dut_o(dut_o_v[2]),
    .drv_a(drv_a_v[2]), .drv_b(drv_b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_cnt(err_v[2]), .fail_vec(fail_v[2]));

  function automatic int hold_of(input int s);
    return (s == 0) ? H0 : (s == 1) ? H1 : H2;
  endfunction

  function automatic int loops_of(input int s);
    return (s == 0) ? L0 : (s == 1) ? L1 : L2;
  endfunction

  function automatic logic [3:0] exp_of(input int s);
    return (s == 0) ? E0 : (s == 1) ? E1 : E2;
  endfunction

  function automatic int exp_err(input logic [3:0] mask, input int loops);
    int c;
    c = $countones(mask) * loops;
    return (c > 255) ? 255 : c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input int s, input string tag);
    check($sformatf("%s u%0d", tag, s),
          32'({drv_a_v[s], drv_b_v[s], busy_v[s], done_v[s], pass_v[s], err_v[s], fail_v[s]}),
          32'd0);
  endtask

  task automatic pulse_start(input int s);
    @(negedge clk);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
  endtask

  // One full run on instance s with the modelled gate table 'gate'. When
  // 'poke' is set, start is also raised during RUN and during the done cycle.
  task automatic run(input int s, input logic [3:0] gate, input bit poke);
    int h, l, n;
    logic [3:0] mask;
    h = hold_of(s);
    l = loops_of(s);
    n = 4 * h * l;
    mask = gate ^ exp_of(s);
    gate_v[s] = gate;
    pulse_start(s);
    // Now one half-cycle after the accepting edge: cycle k = 0.
    for (int k = 0; k < n; k++) begin
      check($sformatf("drv u%0d k=%0d", s, k),
            32'({drv_a_v[s], drv_b_v[s]}), 32'(pat[(k / h) % 4]));
      check($sformatf("busy/done u%0d k=%0d", s, k),
            32'({busy_v[s], done_v[s]}), 32'b10);
      if (poke && k == 2) start_v[s] = 1'b1;
      if (poke && k == 3) start_v[s] = 1'b0;
      @(negedge clk);
    end
    check($sformatf("done-cycle flags u%0d", s),
          32'({busy_v[s], done_v[s], drv_a_v[s], drv_b_v[s]}), 32'b0100);
    check($sformatf("err_cnt u%0d", s), 32'(err_v[s]), 32'(exp_err(mask, l)));
    check($sformatf("fail_vec u%0d", s), 32'(fail_v[s]), 32'(mask));
    check($sformatf("pass u%0d", s), 32'(pass_v[s]), 32'(mask == 4'b0000));
    if (poke) start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    check($sformatf("idle after done u%0d", s),
          32'({busy_v[s], done_v[s], pass_v[s], err_v[s], fail_v[s]}),
          32'({1'b0, 1'b0, mask == 4'b0000, 8'(exp_err(mask, l)), mask}));
    @(negedge clk);
    check($sformatf("start not queued u%0d", s), 32'({busy_v[s], done_v[s]}), 32'b00);
  endtask

  initial begin
    rst     = 1'b0;
    start_v = 3'b000;
    gate_v[0] = TT_OR;
    gate_v[1] = TT_OR;
    gate_v[2] = TT_XOR;

    // 1. Reset, asserted between edges, then 10 idle cycles.
    #1 rst = 1'b1;
    #2;
    for (int s = 0; s < 3; s++) check_all_zero(s, "reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_all_zero(0, $sformatf("idle c=%0d", c));
    end
    check_all_zero(2, "idle end");

    // 2. Correct OR gate.
    run(0, TT_OR, 1'b0);

    // 3. Output stuck at 0 against OR.
    run(0, 4'b0000, 1'b0);

    // Asynchronous reset clears held results without a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero(0, "async rst held results");
    @(negedge clk);
    rst = 1'b0;

    // 4. 100 loops stuck at 0: 300 mismatches saturate at 255.
    run(1, 4'b0000, 1'b0);

    // 5. start pulses during RUN and during the done cycle are ignored.
    run(0, TT_OR, 1'b1);

    // 6. Reset during pattern 11, then a clean restart.
    gate_v[0] = TT_OR;
    pulse_start(0);
    for (int k = 0; k < 9; k++) @(negedge clk);
    check("drv before mid-run rst", 32'({drv_a_v[0], drv_b_v[0]}), 32'b11);
    #2 rst = 1'b1;
    #1 check_all_zero(0, "mid-run rst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("no done after abort c=%0d", c),
            32'({busy_v[0], done_v[0]}), 32'b00);
    end
    run(0, TT_OR, 1'b0);

    // Randomised gate tables, including the HOLD_CYCLES=1 instance.
    run(2, TT_AND, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run(2, 4'($urandom_range(0, 15)), 1'($urandom));
      run(0, 4'($urandom_range(0, 15)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_gate_tt_sequencer

// File: doc/gate_tt_sequencer.md
# gate_tt_sequencer

Self-checking stimulus stage for 2-input gate modules. It sits directly upstream of the gate under test, driving its `A`/`B` inputs through the full truth table in Gray order (00, 10, 11, 01), and reads back the gate's `O`. It compares each result against a parameterised expected truth table and reports per-pattern failures, an error count and pass/fail on a one-cycle `done` pulse. This gives OR/AND/XOR gate blocks a synthesizable, reusable exerciser in place of hand-written `initial` sequences.

## Interface
Parameters:
- `HOLD_CYCLES`, 4: cycles each pattern is held; legal range ≥1.
- `LOOPS`, 1: number of full 4-pattern passes per run; legal range ≥1.
- `EXP_TT`, 4'b1110: expected output indexed by `{A,B}`. Default is OR.
- `ERR_W`, 8: width of the error counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; accepted only in IDLE.
- `dut_o`  in  1  output of the gate under test (combinational from `drv_a`/`drv_b`).
- `drv_a`  out  1  drives the gate's `A`.
- `drv_b`  out  1  drives the gate's `B`.
- `busy`  out  1  high while patterns are being applied.
- `done`  out  1  one-cycle pulse at run end.
- `pass`  out  1  `err_cnt == 0` at run end; held until the next accepted start.
- `err_cnt`  out  ERR_W  number of mismatches; saturates at all-ones.
- `fail_vec`  out  4  sticky per-pattern failure flags, bit index `{A,B}`.

## Operation
- State machine states: IDLE, RUN, DONE.
- IDLE → RUN when `start` is high.
  - Pattern step `idx` is set to 0, hold count to 0 and loop count to 0.
  - `err_cnt`, `fail_vec` and `pass` are cleared.
- RUN drives `{drv_a,drv_b}` = PATTERN[`idx`], where PATTERN = {00, 10, 11, 01}. Only one input changes per step.
- The hold count increments each cycle. At `hold == HOLD_CYCLES-1` the sample edge occurs:
  - Compare `dut_o` against `EXP_TT[{drv_a,drv_b}]`.
  - On mismatch, increment `err_cnt` (saturating) and set `fail_vec[{drv_a,drv_b}]`.
  - Reset the hold count to 0 and advance `idx`. `idx` wraps 3 → 0 and increments the loop count.
- Sample edge of `idx`=3 on the last loop → DONE. The compare result from that edge is included.
- DONE lasts exactly one cycle, then returns to IDLE.
  - `done`=1; `pass`=(`err_cnt`==0) is registered.
  - `drv_a`/`drv_b` return to 0.
- `start` is ignored in RUN and DONE. It is not queued.
- `err_cnt` and `fail_vec` hold their values in IDLE until the next accepted start.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `drv_a`=`drv_b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0.
- Reset asserted mid-run aborts the run with no `done` pulse.
- `start` sampled at edge E0 → from E0: `busy`=1, drive=00.
- Each pattern is driven for exactly `HOLD_CYCLES` cycles. `dut_o` is sampled at the last edge of each pattern's window.
- `done` is high in the cycle following edge E0 + 4·HOLD_CYCLES·LOOPS. In that cycle, `busy`=0 and `err_cnt`/`fail_vec`/`pass` are final.
- Earliest next accepted start is at the edge after the `done` cycle (in IDLE).
- All outputs are registered; no combinational path from `dut_o` to any output.

## Structure
- Package `gate_tt_pkg` contains:
  - the state enum (IDLE/RUN/DONE);
  - the PATTERN constant {2'b00, 2'b10, 2'b11, 2'b01};
  - truth-table constants TT_OR=4'b1110, TT_AND=4'b1000, TT_XOR=4'b0110.
- One sub-module: `sat_counter`, a parameterised width, clear, inc and saturate counter used for `err_cnt`.
- Hold and loop counters are inline.

## Test plan
1. Reset: assert `rst` asynchronously between edges → all outputs are 0 immediately. Release, with no `start` for 10 cycles → outputs stay 0.
2. Correct OR gate (`HOLD_CYCLES`=4, `LOOPS`=1, TT_OR):
   - `start` pulse → `drv` sequence 00,10,11,01, 4 cycles each.
   - `done` in cycle 16 after acceptance, with `pass`=1, `err_cnt`=0, `fail_vec`=0.
3. `dut_o` stuck at 0 against TT_OR → `err_cnt`=3, `fail_vec`=4'b1110, `pass`=0.
4. `LOOPS`=100 with `dut_o` stuck at 0 → 300 mismatches. `err_cnt` saturates at 255, `pass`=0, `done` after 1600 cycles.
5. `start` pulsed during RUN and during the DONE cycle → ignored. Exactly one `done`, and the pattern order is unchanged.
6. `rst` asserted during pattern 11 → outputs are 0 at once with no `done`. A new `start` restarts at 00 with cleared counters and completes with `pass`=1 on a correct gate.
